// File: rtl/node_interface.sv
// Network interface between a core and its router's local port: a TX FIFO that injects
// single-flit packets, and an RX FIFO that accepts flits addressed to this node.
module node_interface #(
  parameter int unsigned CS = 2,
  parameter int unsigned DW = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PL = 1 + 4 * CS + DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CS-1:0] node_x,
  input  logic [CS-1:0] node_y,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic [CS-1:0] tx_dest_x,
  input  logic [CS-1:0] tx_dest_y,
  input  logic [DW-1:0] tx_data,
  output logic [0:PL-1] net_out,
  input  logic          net_avail,
  input  logic [0:PL-1] net_in,
  output logic          net_ready,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [CS-1:0] rx_src_x,
  output logic [CS-1:0] rx_src_y,
  output logic [DW-1:0] rx_data,
  output logic [7:0]    misroute_cnt,
  output logic [7:0]    overflow_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 4 * CS + DW;
  localparam int unsigned RW = 2 * CS + DW;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // ---------------------------------------------------------------- TX path
  logic [EW-1:0] tx_mem [DEPTH];
  ptr_t          tx_wr_q, tx_rd_q;
  cnt_t          tx_cnt_q, tx_cnt_d;
  logic          tx_push, tx_pop;

  assign tx_ready = (tx_cnt_q != cnt_t'(DEPTH));
  assign tx_push  = tx_valid && tx_ready;
  assign tx_pop   = (tx_cnt_q != '0) && net_avail;

  always_comb begin
    tx_cnt_d = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      net_out  <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + ptr_t'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + ptr_t'(1);
      tx_cnt_q <= tx_cnt_d;
      net_out  <= tx_pop ? {1'b1, tx_mem[tx_rd_q]} : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= {tx_dest_x, tx_dest_y, node_x, node_y, tx_data};
  end

  // ---------------------------------------------------------------- RX path
  logic          in_valid;
  logic [CS-1:0] in_dx, in_dy, in_sx, in_sy;
  logic [DW-1:0] in_data;

  assign in_valid = net_in[0];
  assign in_dx    = net_in[1:CS];
  assign in_dy    = net_in[CS+1:2*CS];
  assign in_sx    = net_in[2*CS+1:3*CS];
  assign in_sy    = net_in[3*CS+1:4*CS];
  assign in_data  = net_in[4*CS+1:PL-1];

  logic [RW-1:0] rx_mem [DEPTH];
  ptr_t          rx_wr_q, rx_rd_q;
  cnt_t          rx_cnt_q, rx_cnt_d;
  logic          rx_match, rx_full, rx_push, rx_pop;
  logic [RW-1:0] rx_head;
  logic [7:0]    misroute_q, overflow_q;

  assign rx_match = (in_dx == node_x) && (in_dy == node_y);
  // Fullness is judged before this edge's pop, so a flit arriving at a full FIFO is dropped.
  assign rx_full  = (rx_cnt_q == cnt_t'(DEPTH));
  assign rx_push  = in_valid && rx_match && !rx_full;
  assign rx_valid = (rx_cnt_q != '0);
  assign rx_pop   = rx_valid && rx_ready;

  always_comb begin
    rx_cnt_d = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      net_ready  <= 1'b1;
      misroute_q <= '0;
      overflow_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + ptr_t'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + ptr_t'(1);
      rx_cnt_q  <= rx_cnt_d;
      // Keep one free slot in reserve for a flit already in flight from the router.
      net_ready <= (rx_cnt_d <= cnt_t'(DEPTH - 2));
      if (in_valid && !rx_match && misroute_q != 8'hFF) misroute_q <= misroute_q + 8'd1;
      if (in_valid && rx_match && rx_full && overflow_q != 8'hFF) overflow_q <= overflow_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= {in_sx, in_sy, in_data};
  end

  assign rx_head = rx_valid ? rx_mem[rx_rd_q] : '0;
  assign {rx_src_x, rx_src_y, rx_data} = rx_head;
  assign misroute_cnt = misroute_q;
  assign overflow_cnt = overflow_q;

endmodule

// File: tb/tb_node_interface.sv
// Randomized and directed bench for node_interface; a queue-based reference model predicts
// the outputs after every edge and a separate monitor compares them.
module tb_node_interface;

  localparam int CS = 2;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int PL = 1 + 4 * CS + DW;
  localparam int RW = 2 * CS + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [CS-1:0] node_x, node_y;
  logic          tx_valid, tx_ready;
  logic [CS-1:0] tx_dest_x, tx_dest_y;
  logic [DW-1:0] tx_data;
  logic [0:PL-1] net_out, net_in;
  logic          net_avail, net_ready;
  logic          rx_valid, rx_ready;
  logic [CS-1:0] rx_src_x, rx_src_y;
  logic [DW-1:0] rx_data;
  logic [7:0]    misroute_cnt, overflow_cnt;

  node_interface #(.CS(CS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .node_x(node_x), .node_y(node_y),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y),
    .tx_data(tx_data), .net_out(net_out), .net_avail(net_avail), .net_in(net_in),
    .net_ready(net_ready), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src_x(rx_src_x),
    .rx_src_y(rx_src_y), .rx_data(rx_data), .misroute_cnt(misroute_cnt),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:PL-1] net_out;
    logic          tx_ready;
    logic          net_ready;
    logic          rx_valid;
    logic [RW-1:0] head;
    int            mis;
    int            ovf;
  } snap_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [0:PL-1] mk(input logic [CS-1:0] dx, input logic [CS-1:0] dy,
                                       input logic [CS-1:0] sx, input logic [CS-1:0] sy,
                                       input logic [DW-1:0] d);
    return {1'b1, dx, dy, sx, sy, d};
  endfunction

  // Reference model: plain queues standing in for the two FIFOs.
  logic [0:PL-1] m_tx[$];
  logic [RW-1:0] m_rx[$];
  int            m_mis, m_ovf;
  snap_t         exp_q[$];

  always @(posedge clk or posedge rst) begin
    logic [0:PL-1] launched;
    logic [RW-1:0] dummy;
    snap_t         s;
    int            tx_n, rx_n;
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_mis = 0;
      m_ovf = 0;
    end else begin
      tx_n = m_tx.size();
      rx_n = m_rx.size();
      launched = '0;
      if (tx_n > 0 && net_avail) launched = m_tx.pop_front();
      if (tx_valid && tx_n < DEPTH) m_tx.push_back(mk(tx_dest_x, tx_dest_y, node_x, node_y, tx_data));
      if (rx_ready && rx_n > 0) dummy = m_rx.pop_front();
      if (net_in[0]) begin
        if (net_in[1:CS] != node_x || net_in[CS+1:2*CS] != node_y) begin
          if (m_mis < 255) m_mis++;
        end else if (rx_n >= DEPTH) begin
          if (m_ovf < 255) m_ovf++;
        end else begin
          m_rx.push_back(net_in[2*CS+1:PL-1]);
        end
      end
      s.net_out   = launched;
      s.tx_ready  = (m_tx.size() < DEPTH);
      s.net_ready = (DEPTH - m_rx.size() >= 2);
      s.rx_valid  = (m_rx.size() > 0);
      s.head      = (m_rx.size() > 0) ? m_rx[0] : '0;
      s.mis       = m_mis;
      s.ovf       = m_ovf;
      exp_q.push_back(s);
    end
  end

  // Monitor: compares outputs mid-cycle against the prediction for the preceding edge.
  always @(negedge clk) begin
    snap_t e;
    if (rst) begin
      exp_q.delete();
      chk("rst_net_out", 64'(net_out), 64'd0);
      chk("rst_tx_ready", 64'(tx_ready), 64'd1);
      chk("rst_net_ready", 64'(net_ready), 64'd1);
      chk("rst_rx_valid", 64'(rx_valid), 64'd0);
      chk("rst_rx_head", 64'({rx_src_x, rx_src_y, rx_data}), 64'd0);
      chk("rst_misroute", 64'(misroute_cnt), 64'd0);
      chk("rst_overflow", 64'(overflow_cnt), 64'd0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("net_out", 64'(net_out), 64'(e.net_out));
      chk("tx_ready", 64'(tx_ready), 64'(e.tx_ready));
      chk("net_ready", 64'(net_ready), 64'(e.net_ready));
      chk("rx_valid", 64'(rx_valid), 64'(e.rx_valid));
      chk("rx_head", 64'({rx_src_x, rx_src_y, rx_data}), 64'(e.head));
      chk("misroute_cnt", 64'(misroute_cnt), 64'(e.mis));
      chk("overflow_cnt", 64'(overflow_cnt), 64'(e.ovf));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_req(input logic [CS-1:0] dx, input logic [CS-1:0] dy,
                          input logic [DW-1:0] d);
    tx_valid = 1'b1; tx_dest_x = dx; tx_dest_y = dy; tx_data = d;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic reset_with_node(input logic [CS-1:0] x, input logic [CS-1:0] y);
    @(posedge clk);
    #2 rst = 1'b1;
    node_x = x; node_y = y;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; node_x = 2'd1; node_y = 2'd2;
    tx_valid = 1'b0; tx_dest_x = '0; tx_dest_y = '0; tx_data = '0;
    net_avail = 1'b0; net_in = '0; rx_ready = 1'b0;
    step(3);
    rst = 1'b0;

    // TX burst: fill with the router unavailable, then drain back-to-back.
    for (int k = 1; k <= 4; k++) push_req(2'd3, 2'd0, DW'(16'h1111 * k));
    step();
    net_avail = 1'b1;
    step(6);
    net_avail = 1'b0;

    // TX throttle.
    for (int k = 0; k < 3; k++) push_req(2'd0, 2'd3, DW'($urandom));
    for (int i = 0; i < 8; i++) begin
      net_avail = (i % 2 == 0);
      step();
    end
    net_avail = 1'b0;

    // Reset in the middle of a transfer with three queued requests.
    for (int k = 0; k < 3; k++) push_req(2'd2, 2'd1, DW'($urandom));
    net_avail = 1'b1;
    reset_with_node(2'd2, 2'd2);
    net_avail = 1'b0;

    // RX match then mismatch.
    net_in = mk(2'd2, 2'd2, 2'd0, 2'd1, 16'hBEEF); step();
    net_in = mk(2'd1, 2'd2, 2'd3, 2'd3, 16'h1234); step();
    net_in = '0; step(2);
    rx_ready = 1'b1; step(2);
    rx_ready = 1'b0;

    // RX full: five matching flits with the core stalled.
    for (int k = 0; k < 5; k++) begin
      net_in = mk(2'd2, 2'd2, 2'(k), 2'(k + 1), DW'(16'hA000 + k));
      step();
    end
    net_in = '0; step(2);
    rx_ready = 1'b1; step(6);

    // Random traffic on both paths.
    for (int i = 0; i < 600; i++) begin
      tx_valid  = ($urandom_range(0, 1) == 1);
      tx_dest_x = 2'($urandom); tx_dest_y = 2'($urandom); tx_data = DW'($urandom);
      net_avail = ($urandom_range(0, 2) != 0);
      rx_ready  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 9) < 7)
          net_in = mk(node_x, node_y, 2'($urandom), 2'($urandom), DW'($urandom));
        else
          net_in = mk(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), DW'($urandom));
      end else begin
        net_in = '0;
      end
      step();
    end
    tx_valid = 1'b0; net_in = '0; net_avail = 1'b1; rx_ready = 1'b1;
    step(8);

    // Misroute counter saturation.
    reset_with_node(2'd2, 2'd2);
    for (int i = 0; i < 300; i++) begin
      net_in = mk(2'd1, 2'd2, 2'($urandom), 2'($urandom), DW'($urandom));
      step();
    end
    net_in = '0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
